// File: rtl/exec_pkg.sv
// Shared definitions for the integer execute slice: opcode constants,
// ALU operation encoding, immediate-format codes and jump codes.
package exec_pkg;

  // Opcode field values (instr[31:27])
  localparam logic [4:0] OP_RINT   = 5'b00000;
  localparam logic [4:0] OP_IINT   = 5'b00001;
  localparam logic [4:0] OP_LOAD   = 5'b00010;
  localparam logic [4:0] OP_STORE  = 5'b00011;
  localparam logic [4:0] OP_BRANCH = 5'b00100;
  localparam logic [4:0] OP_JMP    = 5'b00101;
  localparam logic [4:0] OP_CALL   = 5'b00110;
  localparam logic [4:0] OP_JALR   = 5'b00111;
  localparam logic [4:0] OP_LUI    = 5'b01000;
  localparam logic [4:0] OP_FPR    = 5'b01001;
  localparam logic [4:0] OP_EXIT   = 5'b11111;

  // ALU operation encoding
  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_MUL   = 4'b1010,
    ALU_PASSB = 4'b1011,
    ALU_BEQ   = 4'b1100,
    ALU_BNE   = 4'b1101,
    ALU_BLT   = 4'b1110,
    ALU_BGE   = 4'b1111
  } alu_op_e;

  // Immediate format selectors
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Jump kinds
  localparam logic [1:0] J_NONE = 2'b00;
  localparam logic [1:0] J_REL  = 2'b10;
  localparam logic [1:0] J_REG  = 2'b11;

  // Compare/branch operations occupy the 11xx corner of the encoding
  function automatic logic is_cmp_op(input logic [3:0] op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/alu.sv
// Integer ALU for the Execute stage. Purely combinational.
// Ports: a, b (WIDTH-bit operands) in; ctrl (4-bit operation) in;
// result (WIDTH-bit) out; eq (branch condition / equality) out.
module alu
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             eq
);

  alu_op_e          op;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] diff;
  logic             lt_s;
  logic             lt_u;

  assign op    = alu_op_e'(ctrl);
  assign shamt = b[4:0];
  assign diff  = a - b;
  assign lt_s  = ($signed(a) < $signed(b));
  assign lt_u  = (a < b);

  // Result selection; compare ops expose a-b on the result bus
  always_comb begin
    result = {WIDTH{1'b0}};
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = diff;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:   result = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU:  result = {{(WIDTH-1){1'b0}}, lt_u};
      ALU_MUL:   result = a * b;
      ALU_PASSB: result = b;
      ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE: result = diff;
      default:   result = {WIDTH{1'b0}};
    endcase
  end

  // Branch condition for compare ops, plain equality otherwise
  always_comb begin
    eq = (a == b);
    if (is_cmp_op(ctrl)) begin
      case (op)
        ALU_BEQ: eq = (a == b);
        ALU_BNE: eq = (a != b);
        ALU_BLT: eq = lt_s;
        ALU_BGE: eq = ~lt_s;
        default: eq = (a == b);
      endcase
    end else begin
      eq = (a == b);
    end
  end

endmodule

// File: rtl/controlunit.sv
// Instruction decoder for the Decode stage. Purely combinational.
// Ports: instr (32-bit instruction) in; alu_ctrl, alu_src, imm_src,
// reg_write, branch, jump, wdme, is_load, result_src, wd3_src, floating,
// exit out. Unknown opcodes decode as a NOP with every control low.
module controlunit
  import exec_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src,
  output logic [2:0]  imm_src,
  output logic        reg_write,
  output logic        branch,
  output logic [1:0]  jump,
  output logic        wdme,
  output logic        is_load,
  output logic        result_src,
  output logic        wd3_src,
  output logic        floating,
  output logic        exit
);

  logic [4:0] opcode;
  logic [3:0] funct;
  logic       unused_fields;

  assign opcode = instr[31:27];
  assign funct  = instr[13:10];
  // Register specifiers are consumed by the register file, not here
  assign unused_fields = ^{instr[26:14], instr[9:0]};

  // Opcode decode with all controls defaulting to a NOP
  always_comb begin
    alu_ctrl   = 4'b0000;
    alu_src    = 1'b0;
    imm_src    = 3'b000;
    reg_write  = 1'b0;
    branch     = 1'b0;
    jump       = J_NONE;
    wdme       = 1'b0;
    is_load    = 1'b0;
    result_src = 1'b0;
    wd3_src    = 1'b0;
    floating   = 1'b0;
    exit       = 1'b0;
    case (opcode)
      OP_RINT: begin
        alu_ctrl  = funct;
        reg_write = 1'b1;
      end
      OP_IINT: begin
        alu_ctrl  = funct;
        alu_src   = 1'b1;
        imm_src   = IMM_I;
        reg_write = 1'b1;
      end
      OP_LOAD: begin
        alu_ctrl   = ALU_ADD;
        alu_src    = 1'b1;
        imm_src    = IMM_I;
        reg_write  = 1'b1;
        result_src = 1'b1;
        is_load    = 1'b1;
      end
      OP_STORE: begin
        alu_ctrl = ALU_ADD;
        alu_src  = 1'b1;
        imm_src  = IMM_S;
        wdme     = 1'b1;
      end
      OP_BRANCH: begin
        // Low two funct bits pick BEQ/BNE/BLT/BGE
        alu_ctrl = {2'b11, funct[1:0]};
        imm_src  = IMM_B;
        branch   = 1'b1;
      end
      OP_JMP: begin
        jump    = J_REL;
        imm_src = IMM_J;
      end
      OP_CALL: begin
        // Link address goes to r1 via the wd3 path
        jump      = J_REL;
        imm_src   = IMM_J;
        reg_write = 1'b1;
        wd3_src   = 1'b1;
      end
      OP_JALR: begin
        jump     = J_REG;
        alu_ctrl = ALU_ADD;
        alu_src  = 1'b1;
        imm_src  = IMM_I;
      end
      OP_LUI: begin
        alu_ctrl  = ALU_PASSB;
        alu_src   = 1'b1;
        imm_src   = IMM_U;
        reg_write = 1'b1;
      end
      OP_FPR: begin
        floating  = 1'b1;
        alu_ctrl  = funct;
        reg_write = 1'b1;
      end
      OP_EXIT: begin
        exit = 1'b1;
      end
      default: begin
        exit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory for the Memory stage.
// Ports: clk in; rst (active-low, blocks writes) in; we, addr (AW bits),
// wdata (32) in; rdata (32) out. Reads are combinational and wrap at the
// top of the array; writes land on the rising edge. Contents are never
// cleared by reset.
module data_mem #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam logic [AW-1:0] ONE   = AW'(1);
  localparam logic [AW-1:0] TWO   = AW'(2);
  localparam logic [AW-1:0] THREE = AW'(3);

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] a0;
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [AW-1:0] a3;

  // AW-bit arithmetic gives the wrap-around at the array top for free
  assign a0 = addr;
  assign a1 = addr + ONE;
  assign a2 = addr + TWO;
  assign a3 = addr + THREE;

  assign rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};

  // Word store, suppressed while reset is held
  always_ff @(posedge clk) begin
    if (we && rst) begin
      mem[a0] <= wdata[7:0];
      mem[a1] <= wdata[15:8];
      mem[a2] <= wdata[23:16];
      mem[a3] <= wdata[31:24];
    end
  end

endmodule

// File: rtl/exec_slice.sv
// Execute/decode/memory slice of the maths-accelerator pipeline.
// Ports: clk, rst (async active-low); instr -> decode controls
// (alu_ctrl .. exit); alu_a, alu_b, alu_ctrl_e -> alu_result, eq;
// mem_we, mem_addr, mem_wdata -> mem_rdata; halted (sticky EXIT flag).
module exec_slice
  import exec_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MEM_AW = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  output logic [3:0]       alu_ctrl,
  output logic             alu_src,
  output logic [2:0]       imm_src,
  output logic             reg_write,
  output logic             branch,
  output logic [1:0]       jump,
  output logic             wdme,
  output logic             is_load,
  output logic             result_src,
  output logic             wd3_src,
  output logic             floating,
  output logic             exit,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [3:0]       alu_ctrl_e,
  output logic [WIDTH-1:0] alu_result,
  output logic             eq,
  input  logic             mem_we,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] mem_rdata,
  output logic             halted
);

  logic unused_addr_bits;

  // Only the low MEM_AW address bits select a byte
  assign unused_addr_bits = ^mem_addr[WIDTH-1:MEM_AW];

  controlunit u_controlunit (
    .instr      (instr),
    .alu_ctrl   (alu_ctrl),
    .alu_src    (alu_src),
    .imm_src    (imm_src),
    .reg_write  (reg_write),
    .branch     (branch),
    .jump       (jump),
    .wdme       (wdme),
    .is_load    (is_load),
    .result_src (result_src),
    .wd3_src    (wd3_src),
    .floating   (floating),
    .exit       (exit)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .ctrl   (alu_ctrl_e),
    .result (alu_result),
    .eq     (eq)
  );

  data_mem #(.AW(MEM_AW)) u_data_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .addr  (mem_addr[MEM_AW-1:0]),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Sticky halt: set by a decoded EXIT, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted <= 1'b0;
    end else if (exit) begin
      halted <= 1'b1;
    end else begin
      halted <= halted;
    end
  end

endmodule

// File: tb/tb_exec_slice.sv
module tb_exec_slice;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [3:0]  alu_ctrl;
  logic        alu_src;
  logic [2:0]  imm_src;
  logic        reg_write, branch;
  logic [1:0]  jump;
  logic        wdme, is_load, result_src, wd3_src, floating, exit;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl_e;
  logic [31:0] alu_result;
  logic        eq;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        halted;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mm [int];

  exec_slice dut (
    .clk(clk), .rst(rst), .instr(instr),
    .alu_ctrl(alu_ctrl), .alu_src(alu_src), .imm_src(imm_src),
    .reg_write(reg_write), .branch(branch), .jump(jump), .wdme(wdme),
    .is_load(is_load), .result_src(result_src), .wd3_src(wd3_src),
    .floating(floating), .exit(exit),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl_e(alu_ctrl_e),
    .alu_result(alu_result), .eq(eq),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .halted(halted)
  );

  always #5 clk = ~clk;

  wire [17:0] dec_obs = {alu_ctrl, alu_src, imm_src, reg_write, branch, jump,
                         wdme, is_load, result_src, wd3_src, floating, exit};

  // Decode reference: opcode table -> packed control word
  function automatic logic [17:0] dec_model(input logic [31:0] i);
    logic [3:0] f, ac;
    logic [2:0] is;
    logic [1:0] j;
    logic as, rw, br, wd, ld, rs, w3, fl, ex;
    f = i[13:10];
    ac = 4'd0; as = 1'b0; is = 3'd0; rw = 1'b0; br = 1'b0; j = 2'd0;
    wd = 1'b0; ld = 1'b0; rs = 1'b0; w3 = 1'b0; fl = 1'b0; ex = 1'b0;
    case (i[31:27])
      5'd0:  begin ac = f; rw = 1'b1; end
      5'd1:  begin ac = f; as = 1'b1; rw = 1'b1; end
      5'd2:  begin as = 1'b1; rw = 1'b1; rs = 1'b1; ld = 1'b1; end
      5'd3:  begin as = 1'b1; is = 3'd1; wd = 1'b1; end
      5'd4:  begin ac = {2'b11, f[1:0]}; is = 3'd2; br = 1'b1; end
      5'd5:  begin j = 2'b10; is = 3'd3; end
      5'd6:  begin j = 2'b10; is = 3'd3; rw = 1'b1; w3 = 1'b1; end
      5'd7:  begin j = 2'b11; as = 1'b1; end
      5'd8:  begin ac = 4'd11; as = 1'b1; is = 3'd4; rw = 1'b1; end
      5'd9:  begin fl = 1'b1; ac = f; rw = 1'b1; end
      5'd31: ex = 1'b1;
      default: ;
    endcase
    return {ac, as, is, rw, br, j, wd, ld, rs, w3, fl, ex};
  endfunction

  // ALU reference from arithmetic definitions
  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input int op);
    logic [31:0] r;
    logic [63:0] p;
    logic e;
    int sa, sb;
    sa = a; sb = b;
    r = 32'd0;
    e = (a == b);
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a; for (int k = 0; k < int'(b[4:0]); k++) r = {r[30:0], 1'b0}; end
      6: begin r = a; for (int k = 0; k < int'(b[4:0]); k++) r = {1'b0, r[31:1]}; end
      7: begin r = a; for (int k = 0; k < int'(b[4:0]); k++) r = {r[31], r[31:1]}; end
      8: r = (sa < sb) ? 32'd1 : 32'd0;
      9: r = (a < b) ? 32'd1 : 32'd0;
      10: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      11: r = b;
      default: r = a - b;
    endcase
    case (op)
      12: e = (a == b);
      13: e = (a != b);
      14: e = (sa < sb);
      15: e = (sa >= sb);
      default: e = (a == b);
    endcase
    return {e, r};
  endfunction

  function automatic logic [31:0] mem_model(input logic [31:0] ad);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = mm[int'((ad + k) & 32'h1FFFF)];
    return w;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic mem_write(input logic [31:0] ad, input logic [31:0] d);
    @(negedge clk);
    mem_we = 1'b1; mem_addr = ad; mem_wdata = d;
    @(posedge clk);
    #1 mem_we = 1'b0;
    for (int k = 0; k < 4; k++) mm[int'((ad + k) & 32'h1FFFF)] = d[8*k +: 8];
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = 32'd0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
    alu_a = 32'd0; alu_b = 32'd0; alu_ctrl_e = 4'd0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL reset_halted: got %b expected 0", halted);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_decode();
    logic [31:0] dirs [3];
    logic [17:0] exps [3];
    logic [31:0] rnd;
    logic [17:0] e;
    dirs[0] = 32'h1000_0000; exps[0] = 18'b000010001000011000;
    dirs[1] = 32'h3000_0000; exps[1] = 18'b000000111010000100;
    dirs[2] = 32'h5000_0000; exps[2] = 18'b000000000000000000;
    for (int i = 0; i < 3; i++) begin
      instr = dirs[i]; #1;
      n_cmp++;
      if (dec_obs !== exps[i]) begin
        n_fail++; $display("FAIL decode_dir%0d: got %b expected %b", i, dec_obs, exps[i]);
      end
    end
    for (int rep = 0; rep < 3; rep++) begin
      for (int op = 0; op < 32; op++) begin
        rnd = $urandom;
        instr = {op[4:0], rnd[26:0]};
        e = dec_model(instr);
        #1;
        n_cmp++;
        if (dec_obs !== e) begin
          n_fail++; $display("FAIL decode_rand instr=%h: got %b expected %b", instr, dec_obs, e);
        end
      end
    end
    instr = 32'd0;
  endtask

  task automatic test_alu();
    logic [31:0] da [4], db [4], dr [4];
    int dop [4];
    logic [32:0] m;
    da[0] = 32'h7FFF_FFFF; db[0] = 32'd1; dop[0] = 0;  dr[0] = 32'h8000_0000;
    da[1] = 32'hFFFF_FFFF; db[1] = 32'd1; dop[1] = 8;  dr[1] = 32'd1;
    da[2] = 32'hFFFF_FFFF; db[2] = 32'd1; dop[2] = 9;  dr[2] = 32'd0;
    da[3] = 32'h8000_0000; db[3] = 32'd4; dop[3] = 7;  dr[3] = 32'hF800_0000;
    for (int i = 0; i < 4; i++) begin
      alu_a = da[i]; alu_b = db[i]; alu_ctrl_e = 4'(dop[i]); #1;
      n_cmp++;
      if (alu_result !== dr[i]) begin
        n_fail++; $display("FAIL alu_dir%0d: got %h expected %h", i, alu_result, dr[i]);
      end
    end
    for (int rep = 0; rep < 16; rep++) begin
      for (int op = 0; op < 16; op++) begin
        alu_a = pick();
        alu_b = ($urandom_range(0, 3) == 0) ? alu_a : pick();
        alu_ctrl_e = 4'(op);
        m = alu_model(alu_a, alu_b, op);
        #1;
        n_cmp++;
        if ({eq, alu_result} !== m) begin
          n_fail++;
          $display("FAIL alu_rand op=%0d a=%h b=%h: got eq=%b r=%h expected eq=%b r=%h",
                   op, alu_a, alu_b, eq, alu_result, m[32], m[31:0]);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] ba [4], bb [4];
    logic be [4];
    ba[0] = 32'd5;          bb[0] = 32'd5; be[0] = 1'b1;
    ba[1] = 32'd5;          bb[1] = 32'd5; be[1] = 1'b0;
    ba[2] = 32'hFFFF_FFFE;  bb[2] = 32'd1; be[2] = 1'b1;
    ba[3] = 32'hFFFF_FFFE;  bb[3] = 32'd1; be[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alu_a = ba[i]; alu_b = bb[i]; alu_ctrl_e = 4'(12 + i); #1;
      n_cmp++;
      if (eq !== be[i]) begin
        n_fail++; $display("FAIL branch_%0d: got eq=%b expected %b", 12 + i, eq, be[i]);
      end
    end
  endtask

  task automatic test_memory();
    logic [31:0] ad, e;
    mem_write(32'h104, 32'h0000_00AA);
    mem_write(32'h100, 32'hDEAD_BEEF);
    @(negedge clk); mem_addr = 32'h100; #1;
    n_cmp++;
    if (mem_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL mem_aligned: got %h expected deadbeef", mem_rdata);
    end
    mem_addr = 32'h101; #1;
    n_cmp++;
    if (mem_rdata !== 32'hAADE_ADBE) begin
      n_fail++; $display("FAIL mem_unaligned: got %h expected aadeadbe", mem_rdata);
    end
    // same-cycle read of the address being written
    @(negedge clk); mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'h1234_5678; #1;
    n_cmp++;
    if (mem_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL mem_rdw_old: got %h expected deadbeef", mem_rdata);
    end
    @(posedge clk); #1 mem_we = 1'b0;
    for (int k = 0; k < 4; k++) mm[32'h100 + k] = 8'(32'h1234_5678 >> (8 * k));
    n_cmp++;
    if (mem_rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL mem_rdw_new: got %h expected 12345678", mem_rdata);
    end
    // wrap at the top of the array
    mem_write(32'h0, 32'h1122_3344);
    mem_write(32'h1FFFE, 32'hCAFE_F00D);
    @(negedge clk); mem_addr = 32'h0; #1;
    n_cmp++;
    if (mem_rdata !== 32'h1122_CAFE) begin
      n_fail++; $display("FAIL mem_wrap_low: got %h expected 1122cafe", mem_rdata);
    end
    mem_addr = 32'h1FFFE; #1;
    n_cmp++;
    if (mem_rdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL mem_wrap_top: got %h expected cafef00d", mem_rdata);
    end
    // upper address bits ignored
    mem_write(32'hFFF0_0200, 32'h5A5A_A5A5);
    @(negedge clk); mem_addr = 32'h0000_0200; #1;
    n_cmp++;
    if (mem_rdata !== 32'h5A5A_A5A5) begin
      n_fail++; $display("FAIL mem_alias: got %h expected 5a5aa5a5", mem_rdata);
    end
    // random fill, random unaligned overwrites, random reads vs model
    for (int i = 0; i < 64; i++) mem_write(32'h1000 + 4 * i, $urandom);
    for (int i = 0; i < 40; i++) mem_write(32'h1000 + $urandom_range(0, 252), $urandom);
    for (int i = 0; i < 60; i++) begin
      ad = 32'h1000 + $urandom_range(0, 252);
      e = mem_model(ad);
      mem_addr = ad; #1;
      n_cmp++;
      if (mem_rdata !== e) begin
        n_fail++; $display("FAIL mem_rand addr=%h: got %h expected %h", ad, mem_rdata, e);
      end
    end
  endtask

  task automatic test_reset_mem();
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hFFFF_FFFF;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (mem_rdata !== mem_model(32'h100)) begin
      n_fail++; $display("FAIL mem_we_in_reset: got %h expected %h", mem_rdata, mem_model(32'h100));
    end
    // release mid-cycle with a store pending: first write on the next edge
    @(negedge clk); rst = 1'b1; mem_wdata = 32'h0BAD_F00D;
    @(posedge clk); #1 mem_we = 1'b0;
    for (int k = 0; k < 4; k++) mm[32'h100 + k] = 8'(32'h0BAD_F00D >> (8 * k));
    n_cmp++;
    if (mem_rdata !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL mem_after_release: got %h expected 0badf00d", mem_rdata);
    end
  endtask

  task automatic test_halt();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    instr = 32'hF800_0000; #1;
    n_cmp++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_before_edge: got %b expected 0", halted);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_set: got %b expected 1", halted);
    end
    @(negedge clk); instr = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (halted !== 1'b1) begin
        n_fail++; $display("FAIL halt_held cyc%0d: got %b expected 1", i, halted);
      end
    end
    @(negedge clk); #2 rst = 1'b0; #1;
    n_cmp++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_async_clear: got %b expected 0", halted);
    end
    instr = 32'hF800_0000;
    @(posedge clk); #1;
    n_cmp++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_in_reset: got %b expected 0", halted);
    end
    @(negedge clk); instr = 32'd0; rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_after_release: got %b expected 0", halted);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_alu();
    test_branch();
    test_memory();
    test_reset_mem();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
